// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: receiver state encoding and parity modes.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package serial_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5
    } rx_state_e;

    // Parity modes, common to receiver and transmitter
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // True when the received parity bit agrees with the data XOR for the given mode
    function automatic logic parity_ok(input int mode, input logic data_xor, input logic pbit);
        logic ok;
        ok = 1'b1;
        if (mode == PARITY_ODD)  ok = (data_xor ^ pbit) == 1'b1;
        if (mode == PARITY_EVEN) ok = (data_xor ^ pbit) == 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/serial_rx_if.sv
// Byte delivery bus from the UART receiver: data, valid/ready handshake, error flags.
// Latency: n/a (wiring only).
// Backpressure: rx_ready from the consumer; transfer when rx_valid && rx_ready.
interface serial_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       framing_err;
    logic       parity_err;
    logic       overrun;

    // Receiver side drives the byte and flags
    modport master (
        output rx_data, rx_valid, framing_err, parity_err, overrun,
        input  rx_ready
    );

    // Consumer side accepts the byte
    modport slave (
        input  rx_data, rx_valid, framing_err, parity_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/serial_rx_sync.sv
// Two-flop synchronizer for the async serial line plus falling-edge detect.
// Latency: rxd_s_o lags the pin by 2 cycles; fall_o is combinational on the synced line.
// Backpressure: none.
module serial_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rxd_i,
    output logic rxd_s_o,
    output logic fall_o
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Resync chain; resets to the idle (high) line level so reset never looks like an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rxd_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rxd_s_o = sync_q;
    assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/serial_rx.sv
// UART receiver: start/data/parity/stop deserializer into a one-deep holding register.
// Latency: byte valid 1 cycle after the stop-bit sample (pin-to-valid adds the 2-cycle sync).
// Backpressure: holding register full and not consumed at completion -> new byte dropped, overrun pulses.
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PARITY_NONE
) (
    input  logic clk,
    input  logic reset,
    input  logic rxd,
    serial_rx_if.master rx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    // Half-bit wait to land the first sample mid-bit, then full-bit spacing
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic rxd_s;
    logic fall;

    serial_rx_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .rxd_i   (rxd),
        .rxd_s_o (rxd_s),
        .fall_o  (fall)
    );

    rx_state_e            state_q;
    logic [CW-1:0]        baud_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 perr_q;
    logic [7:0]           rx_data_q;
    logic                 rx_valid_q;
    logic                 framing_err_q;
    logic                 parity_err_q;
    logic                 overrun_q;

    // Frame FSM with baud/bit counters, shift register, holding register and registered flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_WAIT_IDLE;
            baud_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            perr_q        <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            framing_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_q     <= 1'b0;

            // Consumer transfer; a byte completing in this same cycle overrides below
            if (rx_valid_q && rx.rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                ST_WAIT_IDLE: begin
                    // A line held low after a bad stop bit must return high before re-arming
                    if (rxd_s) begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (fall) begin
                        state_q    <= ST_START;
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        perr_q     <= 1'b0;
                    end
                end

                ST_START: begin
                    if (baud_cnt_q == HALF_M1) begin
                        baud_cnt_q <= '0;
                        // High at mid start bit means a glitch, not a frame
                        state_q    <= rxd_s ? ST_IDLE : ST_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end

                ST_DATA: begin
                    if (baud_cnt_q == FULL_M1) begin
                        baud_cnt_q <= '0;
                        shift_q    <= {rxd_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q  <= bit_cnt_q + BW'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end

                ST_PARITY: begin
                    if (baud_cnt_q == FULL_M1) begin
                        baud_cnt_q <= '0;
                        perr_q     <= !parity_ok(PARITY, ^shift_q, rxd_s);
                        state_q    <= ST_STOP;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end

                ST_STOP: begin
                    if (baud_cnt_q == FULL_M1) begin
                        baud_cnt_q <= '0;
                        if (rxd_s) begin
                            state_q <= ST_IDLE;
                            if (!rx_valid_q || rx.rx_ready) begin
                                rx_data_q    <= 8'(shift_q);
                                rx_valid_q   <= 1'b1;
                                parity_err_q <= perr_q;
                            end else begin
                                // Old byte wins; parity of the dropped byte is irrelevant
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            framing_err_q <= 1'b1;
                            state_q       <= ST_WAIT_IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CW'(1);
                    end
                end

                default: begin
                    state_q <= ST_WAIT_IDLE;
                end
            endcase
        end
    end

    assign rx.rx_data     = rx_data_q;
    assign rx.rx_valid    = rx_valid_q;
    assign rx.framing_err = framing_err_q;
    assign rx.parity_err  = parity_err_q;
    assign rx.overrun     = overrun_q;

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: one 8N1 receiver and one 8E1 receiver at 10 clocks per bit.
// Latency: n/a.
// Backpressure: rx_ready driven per scenario.
module tb_serial_rx;
    import serial_pkg::*;

    localparam int CPB = 10;

    logic clk;
    logic reset;
    logic rxd0;
    logic rxd1;

    serial_rx_if if0 ();
    serial_rx_if if1 ();

    serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_NONE)) u_rx0 (
        .clk   (clk),
        .reset (reset),
        .rxd   (rxd0),
        .rx    (if0)
    );

    serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_EVEN)) u_rx1 (
        .clk   (clk),
        .reset (reset),
        .rxd   (rxd1),
        .rx    (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Event counters per receiver, sampled on the falling edge
    int         n_rise[2];
    int         n_fe[2];
    int         n_pe[2];
    int         n_ov[2];
    int         n_pe_at_rise[2];
    logic [7:0] data_at_rise[2];
    longint     rise_time[2];
    bit         pv[2];
    longint     start_time;

    task automatic mon(input int d, input logic v, input logic [7:0] dat,
                       input logic fe, input logic pe, input logic ov);
        if (v && !pv[d]) begin
            n_rise[d]++;
            data_at_rise[d] = dat;
            rise_time[d]    = $time;
            if (pe) n_pe_at_rise[d]++;
        end
        if (fe) n_fe[d]++;
        if (pe) n_pe[d]++;
        if (ov) n_ov[d]++;
        pv[d] = v;
    endtask

    always @(negedge clk) begin
        mon(0, if0.rx_valid, if0.rx_data, if0.framing_err, if0.parity_err, if0.overrun);
        mon(1, if1.rx_valid, if1.rx_data, if1.framing_err, if1.parity_err, if1.overrun);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance n clocks, landing 1 time unit after the edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int d, input logic v, input int n);
        if (d == 0) rxd0 = v; else rxd1 = v;
        tick(n);
    endtask

    task automatic send(input int d, input logic [7:0] data, input logic has_par,
                        input logic pbit, input logic stop);
        start_time = $time;
        drive(d, 1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(d, data[i], CPB);
        if (has_par) drive(d, pbit, CPB);
        drive(d, stop, CPB);
        if (d == 0) rxd0 = 1'b1; else rxd1 = 1'b1;
    endtask

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       pbit;
        logic       stop;
        int         exp_rise;
        logic [7:0] exp_data;
        int         exp_pe;
        int         exp_fe;
        int         exp_ofs;
    } vec_t;

    vec_t vt[8];

    initial begin
        int d;
        int r0, pe0, fe0, ov0, pr0;

        // sel, data, parity bit, stop bit, rises, data, parity errs, framing errs, pin-to-valid cycles
        vt[0] = '{0, 8'hA5, 1'b0, 1'b1, 1, 8'hA5, 0, 0, 98};
        vt[1] = '{0, 8'h00, 1'b0, 1'b1, 1, 8'h00, 0, 0, 98};
        vt[2] = '{0, 8'hFF, 1'b0, 1'b1, 1, 8'hFF, 0, 0, 98};
        vt[3] = '{0, 8'h3C, 1'b0, 1'b0, 0, 8'h00, 0, 1, 0};
        vt[4] = '{1, 8'h07, 1'b0, 1'b1, 1, 8'h07, 1, 0, 108};
        vt[5] = '{1, 8'h07, 1'b1, 1'b1, 1, 8'h07, 0, 0, 108};
        vt[6] = '{1, 8'h00, 1'b0, 1'b1, 1, 8'h00, 0, 0, 108};
        vt[7] = '{1, 8'h80, 1'b0, 1'b1, 1, 8'h80, 1, 0, 108};

        reset        = 1'b1;
        rxd0         = 1'b1;
        rxd1         = 1'b1;
        if0.rx_ready = 1'b1;
        if1.rx_ready = 1'b1;
        tick(3);

        chk("reset_valid0", if0.rx_valid, 0);
        chk("reset_data0", if0.rx_data, 0);
        chk("reset_flags0", {if0.framing_err, if0.parity_err, if0.overrun}, 0);
        chk("reset_valid1", if1.rx_valid, 0);
        chk("reset_data1", if1.rx_data, 0);

        reset = 1'b0;
        tick(10);

        // Table of single frames
        for (int i = 0; i < 8; i++) begin
            d   = vt[i].sel;
            r0  = n_rise[d];
            pe0 = n_pe[d];
            fe0 = n_fe[d];
            ov0 = n_ov[d];
            pr0 = n_pe_at_rise[d];
            send(d, vt[i].data, d == 1, vt[i].pbit, vt[i].stop);
            tick(20);
            chk($sformatf("v%0d_rise", i), n_rise[d] - r0, vt[i].exp_rise);
            if (vt[i].exp_rise > 0) begin
                chk($sformatf("v%0d_data", i), data_at_rise[d], vt[i].exp_data);
                chk($sformatf("v%0d_latency", i), rise_time[d] - start_time, 4 + 10 * vt[i].exp_ofs);
            end
            chk($sformatf("v%0d_parity_err", i), n_pe[d] - pe0, vt[i].exp_pe);
            chk($sformatf("v%0d_parity_at_rise", i), n_pe_at_rise[d] - pr0, vt[i].exp_pe);
            chk($sformatf("v%0d_framing_err", i), n_fe[d] - fe0, vt[i].exp_fe);
            chk($sformatf("v%0d_overrun", i), n_ov[d] - ov0, 0);
        end

        // Back-pressure: second byte overruns, first byte is kept
        if0.rx_ready = 1'b0;
        r0  = n_rise[0];
        ov0 = n_ov[0];
        send(0, 8'h12, 1'b0, 1'b0, 1'b1);
        send(0, 8'h34, 1'b0, 1'b0, 1'b1);
        tick(5);
        chk("ovr_rise", n_rise[0] - r0, 1);
        chk("ovr_count", n_ov[0] - ov0, 1);
        chk("ovr_data", if0.rx_data, 8'h12);
        chk("ovr_valid", if0.rx_valid, 1);
        if0.rx_ready = 1'b1;
        tick(1);
        if0.rx_ready = 1'b0;
        chk("ovr_drain_valid", if0.rx_valid, 0);
        tick(3);
        chk("ovr_drain_stays", if0.rx_valid, 0);
        chk("ovr_drain_data", if0.rx_data, 8'h12);
        if0.rx_ready = 1'b1;

        // Framing error followed by a held-low break
        r0  = n_rise[0];
        fe0 = n_fe[0];
        send(0, 8'h5A, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 50);
        drive(0, 1'b1, 20);
        chk("brk_framing", n_fe[0] - fe0, 1);
        chk("brk_no_rise", n_rise[0] - r0, 0);
        send(0, 8'h55, 1'b0, 1'b0, 1'b1);
        tick(20);
        chk("brk_next_rise", n_rise[0] - r0, 1);
        chk("brk_next_data", data_at_rise[0], 8'h55);
        chk("brk_next_no_fe", n_fe[0] - fe0, 1);

        // Short glitch is a false start
        r0  = n_rise[0];
        fe0 = n_fe[0];
        pe0 = n_pe[0];
        ov0 = n_ov[0];
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 40);
        chk("glitch_rise", n_rise[0] - r0, 0);
        chk("glitch_flags", (n_fe[0] - fe0) + (n_pe[0] - pe0) + (n_ov[0] - ov0), 0);
        chk("glitch_valid", if0.rx_valid, 0);
        r0 = n_rise[0];
        send(0, 8'h81, 1'b0, 1'b0, 1'b1);
        tick(20);
        chk("glitch_after_data", data_at_rise[0], 8'h81);
        chk("glitch_after_rise", n_rise[0] - r0, 1);

        // Reset mid-frame with a byte held
        if0.rx_ready = 1'b0;
        send(0, 8'h99, 1'b0, 1'b0, 1'b1);
        tick(5);
        chk("rst_held_valid", if0.rx_valid, 1);
        drive(0, 1'b0, CPB);
        drive(0, 1'b1, CPB);
        drive(0, 1'b0, 5);
        rxd0  = 1'b1;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("rst_valid", if0.rx_valid, 0);
        chk("rst_data", if0.rx_data, 0);
        chk("rst_flags", {if0.framing_err, if0.parity_err, if0.overrun}, 0);
        tick(20);
        if0.rx_ready = 1'b1;
        r0  = n_rise[0];
        fe0 = n_fe[0];
        send(0, 8'hC3, 1'b0, 1'b0, 1'b1);
        tick(20);
        chk("rst_after_rise", n_rise[0] - r0, 1);
        chk("rst_after_data", data_at_rise[0], 8'hC3);
        chk("rst_after_latency", rise_time[0] - start_time, 4 + 10 * 98);
        chk("rst_after_no_fe", n_fe[0] - fe0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
